// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader and its storage array.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int IMEM_DEPTH  = 2048;
    localparam int IMEM_WORD_W = 64;

    // Low bit position of byte lane k inside a 64-bit word.
    function automatic logic [5:0] lane_lo(input logic [2:0] k);
        return {k, 3'b000};
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 64 instruction storage: synchronous write port, combinational 32-bit half-select read.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  logic [IMEM_WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]       ridx,
    input  logic                   rhi,
    output logic [31:0]            rdata
);

    logic [IMEM_WORD_W-1:0] mem_r [DEPTH];
    logic [IMEM_WORD_W-1:0] word_s;

    // Storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx] <= wdata;
        end
    end

    // Read port: pick the instruction half selected by the fetch address.
    always_comb begin
        word_s = mem_r[ridx];
        rdata  = rhi ? word_s[63:32] : word_s[31:0];
    end

endmodule

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 64-bit instruction words and holds the CPU during loads.
module imem_loader
    import imem_pkg::*;
#(
    parameter  int DEPTH  = IMEM_DEPTH,
    parameter  int ADDR_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_end,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [IDX_W:0]    words_written,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] address,
    output logic [31:0]       out
);

    localparam logic [IDX_W:0] FULL_C = (IDX_W+1)'(DEPTH);

    loader_state_t    state_r, state_s;
    logic [2:0]       lane_r;
    logic [63:0]      asm_r;
    logic [IDX_W:0]   ww_r;
    logic             done_r, ovf_r;
    logic             xfer_s, start_s, commit_s, we_s;
    logic [63:0]      word_s;
    logic             unused_addr_s;

    // Next state and word-commit decision.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        commit_s = 1'b0;
        word_s   = asm_r;
        xfer_s   = (state_r == LOAD) && byte_valid;
        case (state_r)
            IDLE, DONE: begin
                if (load_start) begin
                    state_s = LOAD;
                    start_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                // The eighth byte completes the word straight from the input, not the register.
                if (xfer_s && (lane_r == 3'd7)) begin
                    commit_s = 1'b1;
                    word_s   = {byte_data, asm_r[55:0]};
                end else begin
                    commit_s = 1'b0;
                end
                if (load_end) begin
                    state_s = FLUSH;
                end else begin
                    state_s = LOAD;
                end
            end
            FLUSH: begin
                commit_s = (lane_r != 3'd0);
                state_s  = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        we_s = commit_s && (ww_r != FULL_C);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Byte lane, assembly register, word count and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_r <= 3'd0;
            asm_r  <= 64'd0;
            ww_r   <= '0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (start_s) begin
            lane_r <= 3'd0;
            asm_r  <= 64'd0;
            ww_r   <= '0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (xfer_s) begin
                lane_r <= lane_r + 3'd1;
                if (lane_r == 3'd7) begin
                    asm_r <= 64'd0;
                end else begin
                    asm_r[lane_lo(lane_r) +: 8] <= byte_data;
                end
            end else if (state_r == FLUSH) begin
                lane_r <= 3'd0;
                asm_r  <= 64'd0;
            end
            if (we_s) begin
                ww_r <= ww_r + {{IDX_W{1'b0}}, 1'b1};
            end
            if (commit_s && !we_s) begin
                ovf_r <= 1'b1;
            end
            if (state_r == FLUSH) begin
                done_r <= 1'b1;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .widx  (ww_r[IDX_W-1:0]),
        .wdata (word_s),
        .ridx  (address[IDX_W+2:3]),
        .rhi   (address[2]),
        .rdata (out)
    );

    assign unused_addr_s = ^{address[1:0], address[ADDR_W-1:IDX_W+3]};

    assign busy          = (state_r == LOAD) || (state_r == FLUSH);
    assign cpu_hold      = busy;
    assign byte_ready    = (state_r == LOAD);
    assign done          = done_r;
    assign overflow      = ovf_r;
    assign words_written = ww_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench: a full-size and a DEPTH=4 loader share stimulus and are compared to a byte-queue model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        load_end = 1'b0;
    logic [31:0] address = 32'd0;

    logic        ready_b, busy_b, done_b, ovf_b, hold_b;
    logic [11:0] ww_b;
    logic [31:0] out_b;
    logic        ready_s, busy_s, done_s, ovf_s, hold_s;
    logic [2:0]  ww_s;
    logic [31:0] out_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: index 0 = DEPTH 2048 instance, index 1 = DEPTH 4 instance.
    int          depth_of [2] = '{2048, 4};
    logic [63:0] exp_mem  [2][2048];
    bit          known    [2][2048];
    int          exp_ww   [2];
    bit          exp_ovf  [2];
    logic [7:0]  q [$];

    always #5 clk = ~clk;

    imem_loader u_big (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(ready_b), .load_end(load_end), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .words_written(ww_b), .cpu_hold(hold_b),
        .address(address), .out(out_b)
    );

    imem_loader #(.DEPTH(4)) u_small (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(ready_s), .load_end(load_end), .busy(busy_s),
        .done(done_s), .overflow(ovf_s), .words_written(ww_s), .cpu_hold(hold_s),
        .address(address), .out(out_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack_word(input int w);
        logic [63:0] r = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (w * 8 + b < q.size()) r[8*b +: 8] = q[w * 8 + b];
        end
        return r;
    endfunction

    // complete=1: partial tail is flushed; complete=0: aborted load keeps only full words.
    task automatic model_commit(input bit complete);
        int nw = complete ? (q.size() + 7) / 8 : q.size() / 8;
        for (int i = 0; i < 2; i++) begin
            exp_ovf[i] = 1'b0;
            for (int w = 0; w < nw; w++) begin
                if (w < depth_of[i]) begin
                    exp_mem[i][w] = pack_word(w);
                    known[i][w]   = 1'b1;
                end else begin
                    exp_ovf[i] = 1'b1;
                end
            end
            exp_ww[i] = (nw < depth_of[i]) ? nw : depth_of[i];
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ww_b"},  64'(ww_b),  64'(exp_ww[0]));
        check({tag, "_ww_s"},  64'(ww_s),  64'(exp_ww[1]));
        check({tag, "_ovf_b"}, 64'(ovf_b), 64'(exp_ovf[0]));
        check({tag, "_ovf_s"}, 64'(ovf_s), 64'(exp_ovf[1]));
    endtask

    task automatic check_reads(input string tag);
        logic [31:0] a;
        int          ib, is;
        logic [63:0] e;
        for (int w = 0; w < 9; w++) begin
            for (int h = 0; h < 2; h++) begin
                a       = $urandom;
                a[13:3] = 11'(w);
                a[2]    = h[0];
                address = a;
                #1;
                ib = int'(a[13:3]);
                is = int'(a[4:3]);
                if (known[0][ib]) begin
                    e = exp_mem[0][ib];
                    check({tag, "_rd_b"}, 64'(out_b), 64'(h != 0 ? e[63:32] : e[31:0]));
                end
                if (known[1][is]) begin
                    e = exp_mem[1][is];
                    check({tag, "_rd_s"}, 64'(out_s), 64'(h != 0 ? e[63:32] : e[31:0]));
                end
            end
        end
    endtask

    // One complete load. base >= 0 gives bytes base, base+1, ...; otherwise random bytes.
    task automatic do_load(input string tag, input int n, input int base, input bit coincide,
                           input int gap_pct, input bit poke);
        int         sent = 0;
        int         cyc  = 0;
        logic [7:0] b;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        q.delete();
        check({tag, "_start_busy"}, 64'({busy_b, busy_s, hold_b, hold_s}), 64'hF);
        check({tag, "_start_clr"},  64'({done_b, done_s, ovf_b, ovf_s, ww_b, ww_s}), 64'd0);
        while (sent < n && cyc < 40 * n + 100) begin
            b          = (base >= 0) ? 8'(base + sent) : 8'($urandom);
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = b;
            load_start = poke && ($urandom_range(7) == 0);
            load_end   = coincide && byte_valid && (sent == n - 1);
            check({tag, "_ready"}, 64'({ready_b, ready_s}), 64'h3);
            step();
            if (byte_valid) begin
                q.push_back(b);
                sent++;
            end
            cyc++;
        end
        if (sent < n) check({tag, "_byte_timeout"}, 64'(sent), 64'(n));
        byte_valid = 1'b0;
        load_start = 1'b0;
        if (!coincide) begin
            load_end = 1'b1;
            step();
        end
        load_end = 1'b0;
        check({tag, "_flush"}, 64'({busy_b, busy_s, ready_b, ready_s, done_b, done_s}), 64'b110000);
        step();
        model_commit(1'b1);
        check({tag, "_done"}, 64'({done_b, done_s, busy_b, busy_s, hold_b, hold_s}), 64'b110000);
        check_status(tag);
        check_reads(tag);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 2048; w++) known[i][w] = 1'b0;
            exp_ww[i]  = 0;
            exp_ovf[i] = 1'b0;
        end

        repeat (3) step();
        check("reset_outs", 64'({busy_b, done_b, ovf_b, ready_b, hold_b, busy_s, done_s, ovf_s, ready_s, hold_s}), 64'd0);
        check_status("reset");
        reset_n = 1'b1;
        step();

        do_load("seq8", 8, 8'h01, 1'b0, 0, 1'b0);
        address = 32'd0;
        #1 check("seq8_addr0", 64'(out_b), 64'h04030201);
        address = 32'd4;
        #1 check("seq8_addr4", 64'(out_b), 64'h08070605);
        check("seq8_ww", 64'(ww_b), 64'd1);

        do_load("seq11", 11, 8'h10, 1'b0, 0, 1'b0);
        address = 32'd8;
        #1 check("seq11_addr8", 64'(out_b), 64'h001A1918);
        check("seq11_ww", 64'(ww_b), 64'd2);

        do_load("coinc8", 8, -1, 1'b1, 0, 1'b0);
        check("coinc8_ww", 64'(ww_b), 64'd1);

        do_load("ovf40", 40, -1, 1'b0, 0, 1'b0);
        check("ovf40_small", 64'({ovf_s, ww_s}), 64'({1'b1, 3'd4}));

        // Abort a load after one full word plus five bytes.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        q.delete();
        byte_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            byte_data = 8'($urandom);
            q.push_back(byte_data);
            step();
        end
        byte_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_async", 64'({busy_b, hold_b, ready_b, done_b, busy_s, hold_s, ready_s, done_s}), 64'd0);
        model_commit(1'b0);
        exp_ww[0] = 0; exp_ww[1] = 0; exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0;
        check_status("abort");
        #3 reset_n = 1'b1;
        step();
        check_reads("abort_keep");
        do_load("reload", 5, -1, 1'b0, 0, 1'b0);

        do_load("poke", 30, -1, 1'b0, 20, 1'b1);

        for (int t = 0; t < 8; t++) begin
            do_load("rand", int'($urandom_range(1, 60)), -1, 1'($urandom_range(1)),
                    int'($urandom_range(0, 50)), 1'($urandom_range(1)));
            load_end = 1'b1;
            step();
            load_end = 1'b0;
            step();
            check("rand_stray_end", 64'({done_b, busy_b, done_s, busy_s}), 64'b1010);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
